// File: rtl/stdp_learn.sv
// Pair-based STDP engine: per-channel spike-age timers drive LTP on post spikes
// and LTD on pre spikes, with saturating weights and host write access.
module stdp_learn #(
    parameter int NUM_PRE   = 4,
    parameter int T_W       = 4,
    parameter int W_W       = 8,
    parameter int WIN       = 8,
    parameter int LTD_SHIFT = 1,
    parameter int INIT_W    = 128,
    parameter int IDX_W     = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     learn_en,
    input  logic [NUM_PRE-1:0]       pre_spike,
    input  logic                     post_spike,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [W_W-1:0]           wr_data,
    output logic [NUM_PRE*W_W-1:0]   weight,
    output logic [NUM_PRE*T_W-1:0]   time_diff,
    output logic                     update_valid,
    output logic [NUM_PRE-1:0]       update_mask,
    output logic [NUM_PRE-1:0]       update_dir
);
    localparam logic [T_W-1:0] T_MAX = '1;
    localparam logic [T_W-1:0] WIN_T = T_W'(WIN);
    localparam logic [W_W-1:0] W_MAX = '1;

    logic [T_W-1:0]     post_t;
    logic [NUM_PRE-1:0] upd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            post_t <= T_MAX;
        else if (post_spike)
            post_t <= T_W'(1);
        else if (post_t != T_MAX)
            post_t <= post_t + T_W'(1);
    end

    for (genvar i = 0; i < NUM_PRE; i++) begin : g_lane
        logic [T_W-1:0] pre_t, dt, delta, td_q;
        logic [W_W-1:0] w_q, w_nxt;
        logic [W_W:0]   d_ext, sum, diff;
        logic           wr_hit, upd_l;

        // A post spike pairs with this channel's last pre spike (dt=0 if coincident);
        // a lone pre spike pairs with the last post spike.
        always_comb begin
            dt = post_spike ? (pre_spike[i] ? {T_W{1'b0}} : pre_t) : post_t;
            delta = '0;
            if (post_spike) begin
                if (dt < WIN_T) delta = WIN_T - dt;
            end else if (pre_spike[i] && (dt < WIN_T)) begin
                delta = (WIN_T - dt) >> LTD_SHIFT;
            end
            wr_hit = wr_en && (wr_idx == IDX_W'(i));
            upd_l  = learn_en && !wr_hit && (delta != '0);
            d_ext  = {{(W_W+1-T_W){1'b0}}, delta};
            sum    = {1'b0, w_q} + d_ext;
            diff   = {1'b0, w_q} - d_ext;
            w_nxt  = w_q;
            if (wr_hit)
                w_nxt = wr_data;
            else if (upd_l)
                w_nxt = post_spike ? (sum[W_W] ? W_MAX : sum[W_W-1:0])
                                   : (diff[W_W] ? '0 : diff[W_W-1:0]);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pre_t <= T_MAX;
                w_q   <= W_W'(INIT_W);
                td_q  <= '0;
            end else begin
                if (pre_spike[i])
                    pre_t <= T_W'(1);
                else if (pre_t != T_MAX)
                    pre_t <= pre_t + T_W'(1);
                w_q <= w_nxt;
                if (upd_l) td_q <= dt;
            end
        end

        assign upd[i]                  = upd_l;
        assign weight[i*W_W +: W_W]    = w_q;
        assign time_diff[i*T_W +: T_W] = td_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_valid <= 1'b0;
            update_mask  <= '0;
            update_dir   <= '0;
        end else begin
            update_valid <= |upd;
            update_mask  <= upd;
            update_dir   <= post_spike ? upd : '0;
        end
    end
endmodule

// File: tb/tb_stdp_learn.sv
// Directed STDP scenarios; expected update records are queued at stimulus time
// and a monitor compares them whenever update_valid is seen.
module tb_stdp_learn;
    logic        clk, rst, learn_en, post_spike, wr_en;
    logic [3:0]  pre_spike;
    logic [1:0]  wr_idx;
    logic [7:0]  wr_data;
    logic [31:0] weight;
    logic [15:0] time_diff;
    logic        update_valid;
    logic [3:0]  update_mask, update_dir;

    stdp_learn dut (
        .clk(clk), .rst(rst), .learn_en(learn_en), .pre_spike(pre_spike),
        .post_spike(post_spike), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .weight(weight), .time_diff(time_diff), .update_valid(update_valid),
        .update_mask(update_mask), .update_dir(update_dir)
    );

    typedef struct packed {
        logic [3:0]  mask;
        logic [3:0]  dir;
        logic [31:0] w;
        logic [15:0] td;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ew[4];
    logic [3:0] etd[4];
    int         n_chk = 0, n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [31:0] flat_w();
        return {ew[3], ew[2], ew[1], ew[0]};
    endfunction

    function automatic logic [15:0] flat_td();
        return {etd[3], etd[2], etd[1], etd[0]};
    endfunction

    task automatic push(input logic [3:0] mask, input logic [3:0] dir);
        exp_t e;
        e.mask = mask; e.dir = dir; e.w = flat_w(); e.td = flat_td();
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && update_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_update", {60'd0, update_mask}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("upd_mask", {60'd0, update_mask}, {60'd0, e.mask});
                chk("upd_dir", {60'd0, update_dir & update_mask}, {60'd0, e.dir});
                chk("upd_weight", {32'd0, weight}, {32'd0, e.w});
                chk("upd_time_diff", {48'd0, time_diff}, {48'd0, e.td});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [3:0] pre, input logic post);
        pre_spike = pre; post_spike = post;
        tick();
        pre_spike = '0; post_spike = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic host_wr(input logic [1:0] idx, input logic [7:0] d);
        wr_en = 1'b1; wr_idx = idx; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; learn_en = 1'b1; pre_spike = '0; post_spike = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        for (int i = 0; i < 4; i++) begin ew[i] = 8'd128; etd[i] = '0; end
        idle(2);
        rst = 1'b0;
        tick();
        chk("reset_weight", {32'd0, weight}, {32'd0, 32'h80808080});
        chk("reset_time_diff", {48'd0, time_diff}, 64'd0);
        chk("reset_valid", {63'd0, update_valid}, 64'd0);

        // dirty state, then a mid-cycle async reset
        host_wr(2'd0, 8'h55);
        ew[0] = 8'h55;
        chk("host_write", {56'd0, weight[7:0]}, 64'h55);
        cyc(4'b0001, 1'b0); idle(2);
        ew[0] = 8'h5A; etd[0] = 4'd3; push(4'b0001, 4'b0001);
        cyc(4'b0000, 1'b1);
        idle(3);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_weight", {32'd0, weight}, {32'd0, 32'h80808080});
        chk("async_reset_td", {48'd0, time_diff}, 64'd0);
        chk("async_reset_valid", {63'd0, update_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin ew[i] = 8'd128; etd[i] = '0; end
        tick();
        rst = 1'b0;
        idle(20);

        // LTP: pre0 then post 3 cycles later
        cyc(4'b0001, 1'b0); idle(2);
        ew[0] = 8'd133; etd[0] = 4'd3; push(4'b0001, 4'b0001);
        cyc(4'b0000, 1'b1);
        idle(20);

        // LTD: post then pre1 2 cycles later
        cyc(4'b0000, 1'b1); idle(1);
        ew[1] = 8'd125; etd[1] = 4'd2; push(4'b0010, 4'b0000);
        cyc(4'b0010, 1'b0);
        idle(20);

        // Saturation high
        host_wr(2'd2, 8'd253); ew[2] = 8'd253;
        cyc(4'b0100, 1'b0);
        ew[2] = 8'd255; etd[2] = 4'd1; push(4'b0100, 4'b0100);
        cyc(4'b0000, 1'b1);
        idle(20);
        // Saturation low
        host_wr(2'd3, 8'd1); ew[3] = 8'd1;
        cyc(4'b0000, 1'b1);
        ew[3] = 8'd0; etd[3] = 4'd1; push(4'b1000, 4'b0000);
        cyc(4'b1000, 1'b0);
        idle(20);

        // Window edge: dt == WIN gives nothing
        cyc(4'b0001, 1'b0); idle(7);
        cyc(4'b0000, 1'b1);
        chk("window_valid", {63'd0, update_valid}, 64'd0);
        chk("window_weight", {56'd0, weight[7:0]}, 64'd133);
        idle(20);

        // learn_en=0: no change, but pre timer0 still restarts
        learn_en = 1'b0;
        cyc(4'b0001, 1'b0); idle(2);
        cyc(4'b0000, 1'b1);
        chk("noleam_valid", {63'd0, update_valid}, 64'd0);
        chk("nolearn_weight", {56'd0, weight[7:0]}, 64'd133);
        chk("nolearn_td", {60'd0, time_diff[3:0]}, 64'd3);
        learn_en = 1'b1;
        ew[0] = 8'd137; etd[0] = 4'd4; push(4'b0001, 4'b0001);
        cyc(4'b0000, 1'b1);
        idle(20);

        // Coincident pre0 + post: LTP with dt=0
        ew[0] = 8'd145; etd[0] = 4'd0; push(4'b0001, 4'b0001);
        cyc(4'b0001, 1'b1);
        idle(20);

        // Host write beats STDP on ch0; ch1 still learns
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'h10;
        ew[0] = 8'h10; ew[1] = 8'd133; etd[1] = 4'd0; push(4'b0010, 4'b0010);
        cyc(4'b0011, 1'b1);
        wr_en = 1'b0;
        chk("wr_priority_weight", {56'd0, weight[7:0]}, 64'h10);
        idle(20);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
